mdu_seq: RTL and testbench
==========================

# mdu_seq

Parametrised iterative multiply/divide unit with HI/LO registers for the MIPS datapath. It extends the combinational R-type ALU control decode with sequential operations: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. It sits beside the ALU in EX, decodes funct when alu_op selects R-type, and runs a one-bit-per-cycle shift-add multiply or restoring divide. While busy it stalls the pipeline.

## Interface
- WIDTH, 32: operand, HI and LO width (≥4)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  instruction valid in EX this cycle
- alu_op  in  2  main-control ALUOp; unit acts only when 2'b10
- funct  in  6  R-type funct field
- a  in  WIDTH  rs value
- b  in  WIDTH  rt value
- flush  in  1  synchronous cancel of in-flight operation
- stall  out  1  hold EX; request cannot be served this cycle
- rd_data  out  WIDTH  MFHI/MFLO read data
- busy  out  1  multiply/divide in progress
- done  out  1  one-cycle pulse: HI/LO just updated by MULT/DIV
- div_zero  out  1  one-cycle pulse with done when divisor was 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- Decode: `hit = req & alu_op==2'b10 & funct ∈ {011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010010 MFLO, 010001 MTHI, 010011 MTLO}`. Any other funct or alu_op is ignored; no output changes.
- States:
  - IDLE → RUN on an accepted MULT/DIV.
  - RUN → FIX after WIDTH iterations.
  - FIX → IDLE.
  - flush in RUN or FIX → IDLE, with HI/LO unchanged and no done pulse.
- Accept, in IDLE:
  - Latches |a| and |b| (magnitudes for signed ops) and the result signs.
  - Clears the iteration counter.
- Multiply: shift-add over a 2·WIDTH accumulator, one multiplier bit per RUN cycle. In FIX, the 2·WIDTH product is negated if the signs differ (signed only), then {hi,lo} ← product.
- Divide: restoring, one quotient bit per RUN cycle. In FIX:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - lo ← quotient, hi ← remainder.
- Divide by zero: lo ← all ones, hi ← original a, div_zero pulses with done.
- Signed MIN/−1: lo ← MIN, hi ← 0. No flag is raised.
- MTHI/MTLO in IDLE: hi/lo ← a at the next edge.
- MFHI/MFLO: rd_data is combinational. It is hi or lo per funct when hit and not stalled, otherwise 0.
- stall = hit & (busy | state==FIX) (combinational). Requests that arrive while stalled are not accepted; the requester holds them until stall drops.
- Results: hi and lo change only in FIX or on MTHI/MTLO.

## Timing
- Reset (asynchronous, any state):
  - state IDLE; hi, lo, counter and internal operands 0.
  - busy, done, div_zero 0; stall and rd_data 0 while no hit.
  - Any in-flight operation is discarded.
- Accept edge E0 (IDLE, hit, MULT/DIV).
- busy = 1 from after E0 until after E(WIDTH+1).
- RUN iterations occur at edges E1..E(WIDTH).
- FIX writes hi/lo at E(WIDTH+1). After that edge, done = 1 for exactly one cycle and busy = 0.
- Result latency: WIDTH+1 cycles. Back-to-back MULT/DIV: the next one can be accepted at E(WIDTH+1)+1 at the earliest, i.e. in the cycle done is high.
- MTHI/MTLO: hi/lo updated one edge after request; zero stall when IDLE.
- MFHI issued in the done cycle returns the new HI without stall.
- Simultaneous flush and accepting req in IDLE: flush wins, nothing is accepted.
- flush during FIX: the write is suppressed.

## Test plan
- WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF → after 33 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001; stall high throughout.
- MULT a=−7 (0xFFFFFFF9) b=6 → {hi,lo}=0xFFFFFFFF_FFFFFFD6. DIV a=−7 b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- DIVU a=100 b=0 → lo=0xFFFFFFFF, hi=100, div_zero and done pulse together. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0, no div_zero.
- MFLO request 5 cycles after a DIVU starts → stall high until the done cycle, then rd_data equals the new lo. MTHI a=0x1234 when idle → hi=0x1234 next edge, no stall.
- flush mid-RUN (cycle 10) of MULTU 3×5 → back to IDLE, hi/lo keep prior values, no done. Async rst_n low mid-RUN → all outputs 0 immediately.
- WIDTH=8: DIVU 200/7 → lo=28, hi=4, done 9 cycles after accept. alu_op=2'b00 with funct MULT → no response.

Source files
------------

// File: rtl/mdu_seq_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// The EX stage owns the request side (master); the unit owns stall/results (slave).
interface mdu_seq_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             stall;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output req, alu_op, funct, a, b, flush,
    input  stall, rd_data, busy, done, div_zero, hi, lo
  );

  modport slave (
    input  req, alu_op, funct, a, b, flush,
    output stall, rd_data, busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mdu_seq.sv
// Iterative MIPS multiply/divide with HI/LO: one bit per cycle, HI/LO written WIDTH+1 cycles after accept.
// Stalls any hitting request while an operation is in RUN/FIX; MTHI/MTLO/MFHI/MFLO are zero-stall when idle.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  mdu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} stateT;
  stateT state, stateNext;

  logic [CW-1:0]        iterCnt;
  logic [WIDTH-1:0]     opA, opB, hiReg, loReg;
  logic [2*WIDTH-1:0]   acc;
  logic                 isDiv, negRes, negRem, doneReg, divZeroReg;

  logic isR, isMulDiv, isMfhi, isMflo, isMthi, isMtlo, hit;
  logic busyInt, stallInt, idleOk, accept, mtWrite, fixWrite;
  logic opSigned, aNeg, bNeg;
  logic [WIDTH-1:0] magA, magB;

  assign isR      = bus.req && (bus.alu_op == 2'b10);
  assign isMulDiv = isR && (bus.funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
  assign isMfhi   = isR && (bus.funct == FN_MFHI);
  assign isMflo   = isR && (bus.funct == FN_MFLO);
  assign isMthi   = isR && (bus.funct == FN_MTHI);
  assign isMtlo   = isR && (bus.funct == FN_MTLO);
  assign hit      = isMulDiv || isMfhi || isMflo || isMthi || isMtlo;

  assign busyInt  = (state != IDLE);
  assign stallInt = hit && busyInt;
  // flush in the same cycle as a request cancels it before it is taken
  assign idleOk   = (state == IDLE) && !bus.flush;
  assign accept   = isMulDiv && idleOk;
  assign mtWrite  = (isMthi || isMtlo) && idleOk;
  assign fixWrite = (state == FIX) && !bus.flush;

  // funct[0] clear selects the signed variants
  assign opSigned = !bus.funct[0];
  assign aNeg     = opSigned && bus.a[WIDTH-1];
  assign bNeg     = opSigned && bus.b[WIDTH-1];
  assign magA     = aNeg ? -bus.a : bus.a;
  assign magB     = bNeg ? -bus.b : bus.b;

  // One iteration of each algorithm; acc holds {high, low} halves
  logic [WIDTH:0]       mulSum, divTrial;
  logic [WIDTH-1:0]     divDiff;
  logic                 divGe;
  logic [2*WIDTH-1:0]   mulNext, divNext, prodFix;
  logic [WIDTH-1:0]     quoFix, remFix, dzHi;

  assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opA};
  assign mulNext  = acc[0] ? {mulSum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
  assign divTrial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign divGe    = divTrial >= {1'b0, opB};
  assign divDiff  = divTrial[WIDTH-1:0] - opB;
  assign divNext  = {divGe ? divDiff : divTrial[WIDTH-1:0], acc[WIDTH-2:0], divGe};

  assign prodFix  = negRes ? -acc : acc;
  assign quoFix   = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign remFix   = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign dzHi     = negRem ? -opA : opA;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = RUN;
      RUN: begin
        if (bus.flush)                          stateNext = IDLE;
        else if (iterCnt == CW'(WIDTH - 1))     stateNext = FIX;
      end
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iterCnt    <= '0;
      opA        <= '0;
      opB        <= '0;
      acc        <= '0;
      isDiv      <= 1'b0;
      negRes     <= 1'b0;
      negRem     <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
      doneReg    <= 1'b0;
      divZeroReg <= 1'b0;
    end else begin
      doneReg    <= fixWrite;
      divZeroReg <= fixWrite && isDiv && (opB == '0);
      if (accept) begin
        opA     <= magA;
        opB     <= magB;
        isDiv   <= bus.funct[1];
        negRes  <= aNeg ^ bNeg;
        negRem  <= aNeg;
        iterCnt <= '0;
        acc     <= {{WIDTH{1'b0}}, (bus.funct[1] ? magA : magB)};
      end else if (state == RUN && !bus.flush) begin
        acc     <= isDiv ? divNext : mulNext;
        iterCnt <= iterCnt + CW'(1);
      end
      if (fixWrite) begin
        if (!isDiv) begin
          {hiReg, loReg} <= prodFix;
        end else if (opB == '0) begin
          loReg <= '1;
          hiReg <= dzHi;
        end else begin
          loReg <= quoFix;
          hiReg <= remFix;
        end
      end else if (mtWrite) begin
        if (isMthi) hiReg <= bus.a;
        else        loReg <= bus.a;
      end
    end
  end

  assign bus.busy     = busyInt;
  assign bus.stall    = stallInt;
  assign bus.done     = doneReg;
  assign bus.div_zero = divZeroReg;
  assign bus.hi       = hiReg;
  assign bus.lo       = loReg;
  assign bus.rd_data  = (isMfhi && !stallInt) ? hiReg :
                        (isMflo && !stallInt) ? loReg : '0;
endmodule

// File: tb/tb_mdu_seq.sv
// Random and directed checks of mdu_seq at WIDTH=32 and WIDTH=8 against a plain-arithmetic model.
module tb_mdu_seq;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTLO  = 6'b010011;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, flush, use8;
  logic [1:0]  aluOp;
  logic [5:0]  funct;
  logic [31:0] a, b;

  always #5 clk = ~clk;

  mdu_seq_if #(.WIDTH(32)) m32 ();
  mdu_seq_if #(.WIDTH(8))  m8 ();

  assign m32.req    = req & ~use8;
  assign m32.alu_op = aluOp;
  assign m32.funct  = funct;
  assign m32.a      = a;
  assign m32.b      = b;
  assign m32.flush  = flush & ~use8;
  assign m8.req     = req & use8;
  assign m8.alu_op  = aluOp;
  assign m8.funct   = funct;
  assign m8.a       = a[7:0];
  assign m8.b       = b[7:0];
  assign m8.flush   = flush & use8;

  mdu_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(m32));
  mdu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(m8));

  wire [31:0] hiO   = use8 ? {24'b0, m8.hi} : m32.hi;
  wire [31:0] loO   = use8 ? {24'b0, m8.lo} : m32.lo;
  wire [31:0] rdO   = use8 ? {24'b0, m8.rd_data} : m32.rd_data;
  wire        doneO = use8 ? m8.done : m32.done;
  wire        busyO = use8 ? m8.busy : m32.busy;
  wire        stallO = use8 ? m8.stall : m32.stall;
  wire        dzO   = use8 ? m8.div_zero : m32.div_zero;

  int          nChecks = 0;
  int          nFails  = 0;
  logic [31:0] expHi[2];
  logic [31:0] expLo[2];
  logic [5:0]  fnTab[4] = '{MULT, MULTU, DIV, DIVU};

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: signed/unsigned integer arithmetic on 64-bit values, truncated to w bits
  task automatic model(input int w, input logic [5:0] fn, input logic [31:0] ai, input logic [31:0] bi,
                       output logic [31:0] h, output logic [31:0] l, output logic dz);
    longint mask, ua, ub, x, y, q, r;
    logic [63:0] p;
    mask = (longint'(1) << w) - 1;
    ua = longint'(ai) & mask;
    ub = longint'(bi) & mask;
    x = (!fn[0] && ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
    y = (!fn[0] && ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
    dz = 1'b0;
    if (!fn[1]) begin
      p = 64'(x * y);
      l = 32'(p) & 32'(mask);
      h = 32'(p >> w) & 32'(mask);
    end else if (y == 0) begin
      dz = 1'b1;
      l = 32'(mask);
      h = 32'(ua);
    end else begin
      q = x / y;
      r = x % y;
      l = 32'(q) & 32'(mask);
      h = 32'(r) & 32'(mask);
    end
  endtask

  task automatic runOp(input logic [5:0] fn, input logic [31:0] ai, input logic [31:0] bi);
    int w, idx, lat;
    logic [31:0] eH, eL;
    logic eDz;
    w   = use8 ? 8 : 32;
    idx = use8 ? 1 : 0;
    model(w, fn, ai, bi, eH, eL, eDz);
    req = 1'b1; aluOp = 2'b10; funct = fn; a = ai; b = bi;
    #1;
    checkEq("accept_stall", stallO, 0);
    tick;
    req = 1'b0;
    checkEq("busy_after_accept", busyO, 1);
    lat = 0;
    while (!doneO && lat < w + 4) begin
      tick;
      lat++;
    end
    checkEq("latency", lat, w + 1);
    checkEq("hi", hiO, eH);
    checkEq("lo", loO, eL);
    checkEq("div_zero", dzO, eDz);
    checkEq("busy_at_done", busyO, 0);
    expHi[idx] = eH;
    expLo[idx] = eL;
  endtask

  task automatic readBack(input logic [5:0] fn);
    int idx;
    idx = use8 ? 1 : 0;
    req = 1'b1; aluOp = 2'b10; funct = fn;
    #1;
    checkEq("mf_stall", stallO, 0);
    checkEq("mf_rd_data", rdO, (fn == MFHI) ? expHi[idx] : expLo[idx]);
    tick;
    req = 1'b0;
  endtask

  task automatic moveTo(input logic [5:0] fn, input logic [31:0] val);
    int idx;
    logic [31:0] v;
    idx = use8 ? 1 : 0;
    v = use8 ? (val & 32'hFF) : val;
    req = 1'b1; aluOp = 2'b10; funct = fn; a = val;
    #1;
    checkEq("mt_stall", stallO, 0);
    tick;
    req = 1'b0;
    if (fn == MTHI) expHi[idx] = v;
    else            expLo[idx] = v;
    checkEq("mt_hi", hiO, expHi[idx]);
    checkEq("mt_lo", loO, expLo[idx]);
  endtask

  task automatic randomOps(input int n);
    int w, sel, rb;
    logic [31:0] ra, rbv;
    w = use8 ? 8 : 32;
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 7);
      ra  = $urandom;
      rbv = $urandom;
      if (sel == 0) rbv = 0;
      else if (sel == 1) begin ra = 32'(1) << (w - 1); rbv = 32'hFFFF_FFFF; end
      else if (sel == 2) begin ra = $urandom_range(0, 300); rbv = $urandom_range(1, 20); end
      runOp(fnTab[$urandom_range(0, 3)], ra, rbv);
      rb = $urandom_range(0, 2);
      if (rb == 0) readBack(MFHI);
      else if (rb == 1) readBack(MFLO);
      if (i % 5 == 4) moveTo(($urandom_range(0, 1) != 0) ? MTHI : MTLO, $urandom);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n;
    rst_n = 1'b0; req = 1'b0; flush = 1'b0; use8 = 1'b0;
    aluOp = 2'b00; funct = 6'd0; a = 0; b = 0;
    expHi = '{0, 0};
    expLo = '{0, 0};
    repeat (2) tick;
    checkEq("rst_hi", hiO, 0);
    checkEq("rst_lo", loO, 0);
    checkEq("rst_busy", busyO, 0);
    checkEq("rst_done", doneO, 0);
    checkEq("rst_div_zero", dzO, 0);
    checkEq("rst_stall", stallO, 0);
    checkEq("rst_rd_data", rdO, 0);
    rst_n = 1'b1;
    tick;

    // Directed cases
    runOp(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkEq("multu_max_hi", hiO, 32'hFFFF_FFFE);
    checkEq("multu_max_lo", loO, 32'h0000_0001);
    runOp(MULT, 32'hFFFF_FFF9, 32'd6);
    checkEq("mult_neg", {hiO, loO}, 64'hFFFF_FFFF_FFFF_FFD6);
    runOp(DIV, 32'hFFFF_FFF9, 32'd2);
    checkEq("div_neg", {hiO, loO}, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp(DIVU, 32'd100, 32'd0);
    checkEq("divu_zero_flag", {dzO, doneO}, 2'b11);
    runOp(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    checkEq("div_min_flag", dzO, 0);

    // MFLO held while a DIVU runs
    req = 1'b1; aluOp = 2'b10; funct = DIVU; a = 32'd1000; b = 32'd7;
    tick;
    req = 1'b0;
    repeat (4) tick;
    req = 1'b1; funct = MFLO;
    #1;
    seen = 1'b0;
    n = 0;
    while (!doneO && n < 40) begin
      if (!stallO) seen = 1'b1;
      tick;
      n++;
    end
    checkEq("mflo_stall_held", seen, 0);
    checkEq("mflo_done_stall", stallO, 0);
    checkEq("mflo_rd_data", rdO, 32'd142);
    tick;
    req = 1'b0;
    expHi[0] = 32'd6;
    expLo[0] = 32'd142;

    moveTo(MTHI, 32'h0000_1234);
    checkEq("mthi_val", hiO, 32'h0000_1234);

    // Non-R-type ALUOp is ignored
    req = 1'b1; aluOp = 2'b00; funct = MULT; a = 5; b = 5;
    #1;
    checkEq("aluop_stall", stallO, 0);
    tick;
    req = 1'b0; aluOp = 2'b10;
    checkEq("aluop_busy", busyO, 0);
    tick;
    checkEq("aluop_hilo", {hiO, loO}, {expHi[0], expLo[0]});

    // Flush together with an idle request
    req = 1'b1; funct = MULT; flush = 1'b1;
    tick;
    req = 1'b0; flush = 1'b0;
    checkEq("flush_accept_busy", busyO, 0);

    // Flush mid-RUN
    req = 1'b1; funct = MULTU; a = 3; b = 5;
    tick;
    req = 1'b0;
    repeat (9) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    checkEq("flush_run_busy", busyO, 0);
    seen = 1'b0;
    repeat (40) begin
      if (doneO) seen = 1'b1;
      tick;
    end
    checkEq("flush_run_done", seen, 0);
    checkEq("flush_run_hilo", {hiO, loO}, {expHi[0], expLo[0]});

    randomOps(30);

    // Asynchronous reset while running
    moveTo(MTHI, 32'hA5A5_0001);
    moveTo(MTLO, 32'h5A5A_0002);
    req = 1'b1; funct = MULTU; a = $urandom; b = $urandom;
    tick;
    req = 1'b0;
    repeat (10) tick;
    #3;
    rst_n = 1'b0;
    #1;
    checkEq("arst_hi", hiO, 0);
    checkEq("arst_lo", loO, 0);
    checkEq("arst_busy", busyO, 0);
    checkEq("arst_done", doneO, 0);
    expHi = '{0, 0};
    expLo = '{0, 0};
    tick;
    rst_n = 1'b1;
    tick;

    // WIDTH=8 instance
    use8 = 1'b1;
    #1;
    runOp(DIVU, 32'd200, 32'd7);
    checkEq("w8_divu_lo", loO, 32'd28);
    checkEq("w8_divu_hi", hiO, 32'd4);
    randomOps(20);

    // Flush during FIX suppresses the write
    req = 1'b1; aluOp = 2'b10; funct = MULTU; a = 13; b = 11;
    tick;
    req = 1'b0;
    repeat (8) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    checkEq("flush_fix_done", doneO, 0);
    checkEq("flush_fix_busy", busyO, 0);
    checkEq("flush_fix_hilo", {hiO, loO}, {expHi[1], expLo[1]});

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
